// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: strips a 1..W byte header from each AXI Stream packet and repacks the payload MSB-first
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
);
  typedef enum logic [2:0] {IDLE, HEAD, BODY, FLUSH, DRAIN} state_t;
  localparam logic [BYTE_CNT_WD:0]   W_B = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);
  localparam logic [BYTE_CNT_WD+1:0] W_T = (BYTE_CNT_WD+2)'(DATA_BYTE_WD);
  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD:0]    n_q, n_d, r_cnt_q, r_cnt_d;
  logic [DATA_WD-1:0]      r_q, r_d, data_out_q, data_out_d, data_header_q, data_header_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d, keep_header_q, keep_header_d;
  logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic                    valid_header_q, valid_header_d;
  logic [DATA_WD-1:0]      din_m;
  logic [2*DATA_WD-1:0]    cat;
  logic [BYTE_CNT_WD+1:0]  k, total;
  logic                    out_free, in_fire, fits;
  assign out_free     = !valid_out_q || ready_out;
  assign ready_in     = (state_q == HEAD || state_q == BODY) && out_free;
  assign ready_strip  = state_q == IDLE;
  assign in_fire      = valid_in && ready_in;
  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign keep_out     = keep_out_q;
  assign last_out     = last_out_q;
  assign valid_header = valid_header_q;
  assign data_header  = data_header_q;
  assign keep_header  = keep_header_q;
  // Zero unkept input bytes, count them, and append them behind the residue bytes
  always_comb begin
    din_m = '0;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      din_m[DATA_WD-1-8*i -: 8] = keep_in[DATA_BYTE_WD-1-i] ? data_in[DATA_WD-1-8*i -: 8] : 8'h00;
      k = k + (BYTE_CNT_WD+2)'(keep_in[i]);
    end
    cat = {r_q, {DATA_WD{1'b0}}} | ({din_m, {DATA_WD{1'b0}}} >> {r_cnt_q, 3'b000});
    total = {1'b0, r_cnt_q} + k;
    fits = total <= W_T;
  end
  // Next-state, residue, payload-register and header-register logic
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    r_d = r_q;
    r_cnt_d = r_cnt_q;
    valid_out_d = valid_out_q && !ready_out;
    data_out_d = data_out_q;
    keep_out_d = keep_out_q;
    last_out_d = last_out_q;
    valid_header_d = valid_header_q && !ready_header;
    data_header_d = data_header_q;
    keep_header_d = keep_header_q;
    case (state_q)
      IDLE: if (valid_strip) begin
        n_d = {1'b0, byte_strip_cnt} + (BYTE_CNT_WD+1)'(1);
        state_d = HEAD;
      end
      HEAD: if (in_fire) begin
        valid_header_d = 1'b1;
        data_header_d = data_in >> {W_B - n_q, 3'b000};
        keep_header_d = ~({DATA_BYTE_WD{1'b1}} << n_q);
        r_d = data_in << {n_q, 3'b000};
        r_cnt_d = W_B - n_q;
        state_d = !last_in ? BODY : (W_B != n_q ? FLUSH : DRAIN);
      end
      BODY: if (in_fire) begin
        valid_out_d = 1'b1;
        data_out_d = cat[2*DATA_WD-1 -: DATA_WD];
        keep_out_d = (last_in && fits) ? ~({DATA_BYTE_WD{1'b1}} >> total) : '1;
        last_out_d = last_in && fits;
        r_d = cat[DATA_WD-1:0];
        r_cnt_d = !last_in ? r_cnt_q : (fits ? '0 : (BYTE_CNT_WD+1)'(total - W_T));
        state_d = !last_in ? BODY : (fits ? DRAIN : FLUSH);
      end
      FLUSH: if (out_free) begin
        valid_out_d = 1'b1;
        data_out_d = r_q;
        keep_out_d = ~({DATA_BYTE_WD{1'b1}} >> r_cnt_q);
        last_out_d = 1'b1;
        r_cnt_d = '0;
        state_d = DRAIN;
      end
      DRAIN: state_d = (out_free && (!valid_header_q || ready_header)) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q <= '0;
      r_q <= '0;
      r_cnt_q <= '0;
      valid_out_q <= 1'b0;
      data_out_q <= '0;
      keep_out_q <= '0;
      last_out_q <= 1'b0;
      valid_header_q <= 1'b0;
      data_header_q <= '0;
      keep_header_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      r_q <= r_d;
      r_cnt_q <= r_cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q <= data_out_d;
      keep_out_q <= keep_out_d;
      last_out_q <= last_out_d;
      valid_header_q <= valid_header_d;
      data_header_q <= data_header_d;
      keep_header_q <= keep_header_d;
    end
  end
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb_axi_stream_strip_header: directed and random packets checked against a byte-queue reference model
module tb_axi_stream_strip_header;
  logic        clk, rst_n;
  logic        valid_in, last_in, ready_in, valid_out, last_out, ready_out;
  logic [31:0] data_in, data_out, data_header;
  logic [3:0]  keep_in, keep_out, keep_header;
  logic        valid_strip, ready_strip, valid_header, ready_header;
  logic [1:0]  byte_strip_cnt;
  int          n_vec, n_err, mode, hdr_hold;
  logic [36:0] oq[$];
  logic [35:0] hq[$];
  logic [31:0] pd[$];
  logic [3:0]  pk[$];

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header), .ready_header(ready_header)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink readiness: always ready, toggling every 2 cycles, or random; header can be held off
  initial begin
    int cyc;
    cyc = 0;
    ready_out = 1'b1;
    ready_header = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ready_out = mode == 1 ? ((cyc / 2) % 2 == 0) : mode == 2 ? ($urandom_range(0, 1) == 1) : 1'b1;
      ready_header = hdr_hold > 0 ? 1'b0 : mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (hdr_hold > 0) hdr_hold--;
    end
  end

  // Output monitor: records transfers and checks stall stability
  initial begin
    logic so, sh;
    logic [36:0] po;
    logic [35:0] ph;
    so = 1'b0;
    sh = 1'b0;
    po = '0;
    ph = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        so = 1'b0;
        sh = 1'b0;
      end else begin
        if (so) chk("out_hold", 64'({valid_out, last_out, keep_out, data_out}), 64'({1'b1, po}));
        if (sh) chk("hdr_hold", 64'({valid_header, keep_header, data_header}), 64'({1'b1, ph}));
        if (valid_header) chk("strip_busy", 64'(ready_strip), 64'(0));
        if (valid_out && ready_out) oq.push_back({last_out, keep_out, data_out});
        if (valid_header && ready_header) hq.push_back({keep_header, data_header});
        so = valid_out && !ready_out;
        po = {last_out, keep_out, data_out};
        sh = valid_header && !ready_header;
        ph = {keep_header, data_header};
      end
    end
  end

  task automatic send_cfg(input int c);
    int t;
    valid_strip = 1'b1;
    byte_strip_cnt = 2'(c);
    t = 0;
    while (!ready_strip && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("cfg_wait", 64'(t < 300), 64'(1));
    @(negedge clk);
    valid_strip = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    valid_in = 1'b1;
    data_in = d;
    keep_in = k;
    last_in = l;
    t = 0;
    while (!ready_in && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("beat_wait", 64'(t < 300), 64'(1));
    @(negedge clk);
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic run_packet(input int c);
    logic [7:0]  bq[$];
    logic [36:0] eq[$];
    logic [31:0] w, h, d;
    logic [3:0]  k;
    int          n, t;
    n = c + 1;
    foreach (pd[i]) begin
      w = pd[i];
      for (int j = 0; j < 4; j++) if (pk[i][3-j]) bq.push_back(w[31-8*j -: 8]);
    end
    h = '0;
    for (int j = 0; j < n; j++) h = (h << 8) | 32'(bq[j]);
    for (int b = n; b < bq.size(); b += 4) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) if (b + j < bq.size()) begin
        d[31-8*j -: 8] = bq[b+j];
        k[3-j] = 1'b1;
      end
      eq.push_back({b + 4 >= bq.size(), k, d});
    end
    oq.delete();
    hq.delete();
    send_cfg(c);
    foreach (pd[i]) send_beat(pd[i], pk[i], i == pd.size() - 1);
    t = 0;
    while (!ready_strip && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_wait", 64'(t < 300), 64'(1));
    chk("hdr_count", 64'(hq.size()), 64'(1));
    if (hq.size() > 0) chk("hdr", 64'(hq[0]), 64'({4'((1 << n) - 1), h}));
    chk("beat_count", 64'(oq.size()), 64'(eq.size()));
    foreach (eq[i]) if (i < oq.size()) chk($sformatf("beat%0d", i), 64'(oq[i]), 64'(eq[i]));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mode = 0;
    hdr_hold = 0;
    rst_n = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    keep_in = '0;
    last_in = 1'b0;
    valid_strip = 1'b0;
    byte_strip_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({valid_out, data_out, keep_out, last_out, ready_in}), 64'(0));
    chk("rst_hdr", 64'({valid_header, data_header, keep_header}), 64'(0));
    chk("rst_strip", 64'(ready_strip), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    pd = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    pk = '{4'hF, 4'hF, 4'hE};
    run_packet(1);
    chk("c1_hdr", 64'(hq[0]), 64'({4'h3, 32'h0000A1A2}));
    chk("c1_b0", 64'(oq[0]), 64'({1'b0, 4'hF, 32'hA3A4B1B2}));
    chk("c1_b1", 64'(oq[1]), 64'({1'b0, 4'hF, 32'hB3B4C1C2}));
    chk("c1_b2", 64'(oq[2]), 64'({1'b1, 4'h8, 32'hC3000000}));

    pd = '{32'h11223344, 32'h55667788};
    pk = '{4'hF, 4'hF};
    run_packet(3);
    chk("c2_b0", 64'(oq[0]), 64'({1'b1, 4'hF, 32'h55667788}));

    pd = '{32'hDEADBEEF};
    pk = '{4'hF};
    run_packet(0);
    chk("c3_hdr", 64'(hq[0]), 64'({4'h1, 32'h000000DE}));
    chk("c3_b0", 64'(oq[0]), 64'({1'b1, 4'hE, 32'hADBEEF00}));

    pd = '{32'hCAFEF00D};
    pk = '{4'hF};
    run_packet(3);
    chk("c4_hdr", 64'(hq[0]), 64'({4'hF, 32'hCAFEF00D}));
    chk("c4_idle", 64'(ready_strip), 64'(1));

    mode = 1;
    hdr_hold = 10;
    pd = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    pk = '{4'hF, 4'hF, 4'hE};
    run_packet(1);
    mode = 0;

    send_cfg(1);
    send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
    send_beat(32'hB1B2B3B4, 4'hF, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst", 64'({valid_out, valid_header, ready_strip}), 64'({1'b0, 1'b0, 1'b1}));
    pd = '{32'hDEADBEEF};
    pk = '{4'hF};
    run_packet(0);

    mode = 2;
    for (int p = 0; p < 25; p++) begin
      int nb, m;
      nb = $urandom_range(1, 5);
      pd.delete();
      pk.delete();
      for (int i = 0; i < nb; i++) begin
        m = (i == nb - 1 && nb > 1) ? $urandom_range(1, 4) : 4;
        pd.push_back($urandom);
        pk.push_back(4'(4'hF << (4 - m)));
      end
      run_packet($urandom_range(0, 3));
    end
    mode = 0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_stream_strip_header.md
Name: axi_stream_strip_header

Overview:
- Receive-side counterpart of the header-insert path. Removes a leading header of 1..DATA_BYTE_WD bytes from each AXI Stream packet.
- Presents the header on a side channel, right-aligned.
- Re-packs the remaining payload into full, MSB-first beats with an MSB-aligned keep on the last beat.
- Sits at the stream sink, before payload consumers.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (W).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the header length field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input data; byte order MSB-first (byte 0 = [DATA_WD-1 -: 8]).
- keep_in  in  DATA_BYTE_WD  byte enables, contiguous from MSB.
- last_in  in  1  last beat of packet.
- ready_in  out  1  input ready.
- valid_out  out  1  payload beat valid.
- data_out  out  DATA_WD  payload data, MSB-first, unused bytes zero.
- keep_out  out  DATA_BYTE_WD  payload byte enables, contiguous from MSB.
- last_out  out  1  last payload beat.
- ready_out  in  1  payload ready.
- valid_strip  in  1  per-packet strip configuration valid.
- byte_strip_cnt  in  BYTE_CNT_WD  header length N = byte_strip_cnt+1 bytes.
- ready_strip  out  1  configuration ready.
- valid_header  out  1  extracted header valid.
- data_header  out  DATA_WD  header bytes right-aligned (LSBs), upper bytes zero.
- keep_header  out  DATA_BYTE_WD  (1<<N)-1.
- ready_header  in  1  header ready.

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: all outputs 0 except ready_strip=1; state IDLE; residue count 0.
- Handshake: a transfer occurs when valid&&ready on the respective channel.
  - valid_out, data_out, keep_out and last_out are registered and hold stable while valid_out && !ready_out.
  - valid_header and its data hold stable until ready_header.
- ready_in = (state==HEAD || state==BODY) && (!valid_out || ready_out).
- Residue register R holds r_cnt leftover bytes, MSB-aligned.
- FSM:
  - IDLE: ready_strip=1. On a strip handshake, latch N and go to HEAD.
  - HEAD: accept the first beat; keep_in must be all-ones (upstream guarantee).
    - Top N bytes go to the header register (right-aligned); valid_header is set the next cycle.
    - Remaining W-N bytes go to R, r_cnt=W-N; no payload is emitted.
    - If last_in: r_cnt>0 -> FLUSH; r_cnt==0 -> DRAIN (header only, no payload beat).
    - Otherwise -> BODY.
  - BODY: on an accepted beat with k bytes, concatenate R (r_cnt bytes) with the input bytes.
    - Not last: emit the top W bytes (keep all-ones); the remaining r_cnt bytes stay in R.
    - Last with r_cnt+k<=W: emit one beat, keep = top (r_cnt+k) ones, last_out=1 -> DRAIN.
    - Last with r_cnt+k>W: emit a full beat (last_out=0); R keeps r_cnt+k-W bytes -> FLUSH.
  - FLUSH: ready_in=0. When the output register is free, emit R with keep = top r_cnt ones, last_out=1 -> DRAIN.
  - DRAIN: wait until the last payload beat (if any) and the header have both been transferred -> IDLE.
- N==W: no shift; the payload passes through with one cycle of latency.
- Latency: a payload beat appears 1 cycle after the input beat that completes it.
- Header output is independent of payload backpressure; both may transfer in the same cycle.
- Configuration for packet n+1 is not accepted until DRAIN exits (ready_strip=0 outside IDLE).
- Reset mid-packet: all state is cleared within the cycle; partial packet and header are discarded.
- Widths: all shifts are computed in byte units multiplied by 8; r_cnt+k is held in BYTE_CNT_WD+2 bits, so there is no wrap.

Test Plan:
- W=4, cnt=1 (N=2); beats A1A2A3A4, B1B2B3B4 keep F, C1C2C3C4 keep 1110 last:
  - header 0x0000A1A2, keep 0011.
  - payload A3A4B1B2/F, then B3B4C1C2/F, then C3000000/1000 with last via FLUSH.
- cnt=3 (N=4); beats 11223344, 55667788 last keep F -> header 0x11223344/F; payload 55667788/F with last.
- cnt=0 (N=1); single beat DEADBEEF keep F last -> header 0x000000DE/0001; payload ADBEEF00/1110 with last.
- cnt=3; single beat CAFEF00D last:
  - header 0xCAFEF00D/F; no valid_out pulse.
  - ready_strip returns high after the header transfer.
- Payload backpressure: case 1 with ready_out toggling every 2 cycles and ready_header held low 10 cycles:
  - outputs stay stable while stalled; no byte is lost or duplicated.
  - ready_strip stays 0 until the header transfers.
- Reset: rst_n low for 1 cycle mid-BODY:
  - next cycle valid_out=0, valid_header=0, ready_strip=1.
  - a fresh packet then strips correctly.
